// File: rtl/uart_tx_peripheral.sv
// uart_tx_peripheral: memory-mapped 8N1 UART transmitter
// with a small TX FIFO and a polled status word.
module uart_tx_peripheral #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int BAUD_DIV   = 434,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  UART_En,
  input  logic [ADDR_WIDTH-1:0] ADDRIn,
  input  logic [DATA_WIDTH-1:0] DataIn,
  output logic [DATA_WIDTH-1:0] DataOut,
  output logic                  tx,
  output logic                  irq
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] BAUD_LD = CW'(BAUD_DIV - 1);
  localparam logic [4:0] DEPTH = 5'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state;
  logic [CW-1:0] baud;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [4:0]    count;
  logic [4:0]    count_n;
  logic          overflow;

  logic sel_tx;
  logic sel_st;
  logic full;
  logic empty;
  logic busy;
  logic baud_end;
  logic frame_free;
  logic push;
  logic pop;
  logic idle_n;
  logic unused_data;

  assign sel_tx     = (ADDRIn == '0);
  assign sel_st     = (ADDRIn == ADDR_WIDTH'(4));
  assign full       = (count == DEPTH);
  assign empty      = (count == 5'd0);
  assign busy       = (state != IDLE);
  assign baud_end   = (baud == '0);
  assign frame_free = (state == IDLE) ||
                      (state == STOP && baud_end);
  assign push       = UART_En && sel_tx && !full;
  assign pop        = frame_free && !empty;
  assign idle_n     = frame_free && empty;
  assign unused_data = ^DataIn[DATA_WIDTH-1:8];

  always_comb begin
    count_n = count;
    if (push && !pop)
      count_n = count + 5'd1;
    else if (pop && !push)
      count_n = count - 5'd1;
  end

  always_comb begin
    DataOut = '0;
    if (sel_st)
      DataOut[8:0] = {count, overflow, busy, empty, full};
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= DataIn[7:0];
  end

  // A push into a full FIFO is dropped even when a pop frees a slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count_n;
      if (UART_En && sel_tx && full)
        overflow <= 1'b1;
      else if (UART_En && sel_st && DataIn[0])
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
      irq     <= 1'b1;
    end else begin
      irq <= idle_n && (count_n == 5'd0);
      unique case (state)
        IDLE: begin
          if (pop) begin
            shift <= mem[rd_ptr];
            baud  <= BAUD_LD;
            tx    <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (baud_end) begin
            baud    <= BAUD_LD;
            bit_idx <= '0;
            tx      <= shift[0];
            state   <= DATA;
          end else begin
            baud <= baud - 1'b1;
          end
        end
        DATA: begin
          if (baud_end) begin
            baud <= BAUD_LD;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              shift   <= shift >> 1;
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift[1];
            end
          end else begin
            baud <= baud - 1'b1;
          end
        end
        STOP: begin
          if (baud_end) begin
            if (pop) begin
              shift <= mem[rd_ptr];
              baud  <= BAUD_LD;
              tx    <= 1'b0;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud <= baud - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_peripheral.sv
// tb_uart_tx_peripheral: scoreboard bench for the UART TX
// peripheral at BAUD_DIV=4, FIFO_DEPTH=4.
module tb_uart_tx_peripheral;

  localparam int B = 4;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        UART_En;
  logic [31:0] ADDRIn;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic        tx;
  logic        irq;

  int n_checks  = 0;
  int n_pass    = 0;
  int frames_rx = 0;

  logic [7:0] sb[$];

  always #5 clk = ~clk;

  uart_tx_peripheral #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .BAUD_DIV(B),
    .FIFO_DEPTH(D)
  ) dut (
    .clk(clk),
    .reset(reset),
    .UART_En(UART_En),
    .ADDRIn(ADDRIn),
    .DataIn(DataIn),
    .DataOut(DataOut),
    .tx(tx),
    .irq(irq)
  );

  // Line decoder: checks every cycle of each frame
  bit         rx_busy = 1'b0;
  int         rx_cnt;
  int         k;
  logic [7:0] rx_byte;
  logic       exp_lvl;

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      rx_busy = 1'b0;
    end else begin
      if (!rx_busy && tx === 1'b0) begin
        rx_busy = 1'b1;
        rx_cnt  = 0;
        n_checks++;
        if (sb.size() == 0) begin
          $display("FAIL frame_unexpected: got start, required none");
          rx_byte = 8'h00;
        end else begin
          n_pass++;
          rx_byte = sb.pop_front();
        end
      end
      if (rx_busy) begin
        k = rx_cnt / B;
        if (k == 0) exp_lvl = 1'b0;
        else if (k == 9) exp_lvl = 1'b1;
        else exp_lvl = rx_byte[k-1];
        n_checks++;
        if (tx !== exp_lvl)
          $display("FAIL frame_bit: byte %h cyc %0d got %b required %b",
                   rx_byte, rx_cnt, tx, exp_lvl);
        else
          n_pass++;
        if (rx_cnt == 10*B-1) begin
          rx_busy = 1'b0;
          frames_rx++;
        end else begin
          rx_cnt++;
        end
      end
    end
  end

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset  = 1'b0;
    ADDRIn = 32'h4;
    #1;
    n_checks++;
    if (DataOut !== 32'h2)
      $display("FAIL reset_status: got %h required 2", DataOut);
    else n_pass++;
    n_checks++;
    if (tx !== 1'b1) $display("FAIL reset_tx: got %b required 1", tx);
    else n_pass++;
    n_checks++;
    if (irq !== 1'b1) $display("FAIL reset_irq: got %b required 1", irq);
    else n_pass++;
    ADDRIn = 32'h0;
    #1;
    n_checks++;
    if (DataOut !== 32'h0)
      $display("FAIL read_txdata: got %h required 0", DataOut);
    else n_pass++;
    ADDRIn = 32'h8;
    #1;
    n_checks++;
    if (DataOut !== 32'h0)
      $display("FAIL read_other: got %h required 0", DataOut);
    else n_pass++;
  endtask

  task automatic test_single;
    int f0;
    f0 = frames_rx;
    @(negedge clk);
    UART_En = 1'b1;
    ADDRIn  = 32'h0;
    DataIn  = 32'hA5;
    sb.push_back(8'hA5);
    @(negedge clk);
    UART_En = 1'b0;
    ADDRIn  = 32'h4;
    #1;
    n_checks++;
    if (tx !== 1'b1) $display("FAIL single_tx_e0: got %b required 1", tx);
    else n_pass++;
    n_checks++;
    if (irq !== 1'b0) $display("FAIL single_irq_e0: got %b required 0", irq);
    else n_pass++;
    n_checks++;
    if (DataOut !== 32'h10)
      $display("FAIL single_status_e0: got %h required 10", DataOut);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (tx !== 1'b0) $display("FAIL single_start: got %b required 0", tx);
    else n_pass++;
    n_checks++;
    if (DataOut !== 32'h6)
      $display("FAIL single_status_busy: got %h required 6", DataOut);
    else n_pass++;
    repeat (39) @(negedge clk);
    n_checks++;
    if (irq !== 1'b0) $display("FAIL single_irq_early: got %b required 0", irq);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (irq !== 1'b1) $display("FAIL single_irq_e41: got %b required 1", irq);
    else n_pass++;
    n_checks++;
    if (DataOut !== 32'h2)
      $display("FAIL single_status_end: got %h required 2", DataOut);
    else n_pass++;
    n_checks++;
    if (frames_rx - f0 !== 1 || sb.size() != 0)
      $display("FAIL single_frames: got %0d left %0d required 1 left 0",
               frames_rx - f0, sb.size());
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    int f0;
    f0 = frames_rx;
    @(negedge clk);
    UART_En = 1'b1;
    ADDRIn  = 32'h0;
    DataIn  = 32'h55;
    sb.push_back(8'h55);
    @(negedge clk);
    DataIn = 32'h0F;
    sb.push_back(8'h0F);
    @(negedge clk);
    UART_En = 1'b0;
    ADDRIn  = 32'h4;
    #1;
    n_checks++;
    if (tx !== 1'b0) $display("FAIL b2b_start1: got %b required 0", tx);
    else n_pass++;
    n_checks++;
    if (DataOut !== 32'h14)
      $display("FAIL b2b_status: got %h required 14", DataOut);
    else n_pass++;
    repeat (40) @(negedge clk);
    n_checks++;
    if (tx !== 1'b0) $display("FAIL b2b_no_gap: got %b required 0", tx);
    else n_pass++;
    n_checks++;
    if (DataOut !== 32'h6)
      $display("FAIL b2b_status2: got %h required 6", DataOut);
    else n_pass++;
    repeat (39) @(negedge clk);
    n_checks++;
    if (irq !== 1'b0) $display("FAIL b2b_irq_early: got %b required 0", irq);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (irq !== 1'b1) $display("FAIL b2b_irq_end: got %b required 1", irq);
    else n_pass++;
    n_checks++;
    if (frames_rx - f0 !== 2 || sb.size() != 0)
      $display("FAIL b2b_frames: got %0d left %0d required 2 left 0",
               frames_rx - f0, sb.size());
    else n_pass++;
  endtask

  task automatic test_overflow;
    int f0;
    int n;
    f0 = frames_rx;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      UART_En = 1'b1;
      ADDRIn  = 32'h0;
      DataIn  = 32'(i + 1);
      if (i < D + 1) sb.push_back(8'(i + 1));
    end
    @(negedge clk);
    UART_En = 1'b0;
    ADDRIn  = 32'h4;
    #1;
    n_checks++;
    if (DataOut !== 32'h4D)
      $display("FAIL ovf_status: got %h required 4d", DataOut);
    else n_pass++;
    n = 0;
    while (irq !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n !== 196) $display("FAIL ovf_idle_time: got %0d required 196", n);
    else n_pass++;
    n_checks++;
    if (frames_rx - f0 !== 5 || sb.size() != 0)
      $display("FAIL ovf_frames: got %0d left %0d required 5 left 0",
               frames_rx - f0, sb.size());
    else n_pass++;
    #1;
    n_checks++;
    if (DataOut !== 32'h0A)
      $display("FAIL ovf_sticky: got %h required 0a", DataOut);
    else n_pass++;
  endtask

  task automatic test_overflow_clear;
    int f0;
    int lows;
    f0 = frames_rx;
    @(negedge clk);
    UART_En = 1'b1;
    ADDRIn  = 32'h4;
    DataIn  = 32'h1;
    #1;
    n_checks++;
    if (DataOut !== 32'h0A)
      $display("FAIL clr_same_cycle: got %h required 0a", DataOut);
    else n_pass++;
    @(negedge clk);
    UART_En = 1'b0;
    #1;
    n_checks++;
    if (DataOut !== 32'h02)
      $display("FAIL clr_next_cycle: got %h required 02", DataOut);
    else n_pass++;
    @(negedge clk);
    UART_En = 1'b1;
    ADDRIn  = 32'h8;
    DataIn  = 32'hFF;
    #1;
    n_checks++;
    if (DataOut !== 32'h0)
      $display("FAIL read_8: got %h required 0", DataOut);
    else n_pass++;
    @(negedge clk);
    UART_En = 1'b0;
    ADDRIn  = 32'h4;
    #1;
    n_checks++;
    if (DataOut !== 32'h02 || irq !== 1'b1)
      $display("FAIL write_8_status: got %h irq %b required 02 irq 1",
               DataOut, irq);
    else n_pass++;
    lows = 0;
    repeat (10) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    n_checks++;
    if (lows !== 0 || frames_rx != f0)
      $display("FAIL write_8_quiet: got %0d low cycles required 0", lows);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame;
    int         f0;
    int         lows;
    logic [7:0] bytes [3];
    bytes[0] = 8'h18;
    bytes[1] = 8'h22;
    bytes[2] = 8'h33;
    f0 = frames_rx;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      UART_En = 1'b1;
      ADDRIn  = 32'h0;
      DataIn  = {24'h0, bytes[i]};
      sb.push_back(bytes[i]);
    end
    @(negedge clk);
    UART_En = 1'b0;
    ADDRIn  = 32'h4;
    repeat (16) @(negedge clk);
    n_checks++;
    if (tx !== 1'b1) $display("FAIL mid_bit3: got %b required 1", tx);
    else n_pass++;
    n_checks++;
    if (DataOut !== 32'h24)
      $display("FAIL mid_status: got %h required 24", DataOut);
    else n_pass++;
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    n_checks++;
    if (tx !== 1'b1 || irq !== 1'b1)
      $display("FAIL mid_reset_line: got tx %b irq %b required 1 1", tx, irq);
    else n_pass++;
    n_checks++;
    if (DataOut !== 32'h02)
      $display("FAIL mid_reset_status: got %h required 02", DataOut);
    else n_pass++;
    reset = 1'b0;
    lows = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    n_checks++;
    if (lows !== 0 || frames_rx != f0)
      $display("FAIL mid_no_frames: got %0d low %0d frames required 0 0",
               lows, frames_rx - f0);
    else n_pass++;
  endtask

  initial begin
    reset   = 1'b1;
    UART_En = 1'b0;
    ADDRIn  = 32'h0;
    DataIn  = 32'h0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_overflow_clear();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_peripheral.md
# uart_tx_peripheral

Memory-mapped UART transmitter that sits directly downstream of the data-memory address decoder in the pipelined RISC-V core. It consumes the decoder's UART write strobe, the rebased address offset and the store data. It buffers bytes in a small FIFO and serialises them as 8N1 frames on a single TX pin. A status word is provided for polled reads through the decoder's read-mux select.

## Interface
- DATA_WIDTH, 32, store/read data width
- ADDR_WIDTH, 32, width of the rebased address offset
- BAUD_DIV, 434, clock cycles per serial bit (50 MHz / 115200); legal range 2..65535
- FIFO_DEPTH, 4, TX FIFO entries; power of two, 2..16

- clk  input  1  core clock
- reset  input  1  synchronous, active-high reset
- UART_En  input  1  write strobe (decoder UARTen & WrtEn); one write per asserted cycle
- ADDRIn  input  ADDR_WIDTH  byte offset within the UART window (decoder ADDROut)
- DataIn  input  DATA_WIDTH  store data
- DataOut  output  DATA_WIDTH  read data, combinational from ADDRIn and registered state
- tx  output  1  serial line, registered, idle high
- irq  output  1  registered; high while FIFO empty and FSM IDLE (transmit complete)

## Operation
- Register map by ADDRIn:
  - 0x0 TXDATA: write pushes DataIn[7:0]; read returns 0.
  - 0x4 STATUS: read returns {0, count[4:0] in [8:4], overflow [3], busy [2], empty [1], full [0]}. Write with DataIn[0]=1 clears overflow.
  - All other offsets: writes ignored, reads return 0.
- FIFO:
  - Push is accepted when UART_En && ADDRIn==0 && count<FIFO_DEPTH, evaluated on pre-edge count.
  - Push while full drops the byte and sets sticky overflow. This holds even if a pop occurs the same cycle.
  - Push and pop in the same cycle leave count unchanged; pointers wrap modulo FIFO_DEPTH.
  - Overflow set and clear in the same cycle: set wins.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If FIFO non-empty: pop into 8-bit shift reg, load baud counter with BAUD_DIV-1, go to START.
  - START: tx=0 for BAUD_DIV cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0], LSB first. Each bit lasts BAUD_DIV cycles, then shift right. After bit index 7, go to STOP.
  - STOP: tx=1 for BAUD_DIV cycles. At the end, if FIFO non-empty, pop and go straight to START with no idle gap; otherwise go to IDLE.
- Baud counter: counts down BAUD_DIV-1..0; a state/bit advances on the cycle it reads 0. Width is clog2(BAUD_DIV).
- busy = FSM not IDLE. full/empty are derived from count.

## Timing
- Reset (synchronous, checked at clock edge) values:
  - tx=1, irq=1, state=IDLE, count=0, pointers=0, overflow=0, shift reg=0, baud counter=0.
  - DataOut reflects the reset state.
- Reset mid-frame aborts the frame: tx is 1 at the next edge and all queued bytes are discarded.
- Latency:
  - A write sampled at edge E0 makes the FIFO non-empty after E0. The FSM pops at E1, and tx falls at E1, one clock after the write.
  - Frame length is exactly 10*BAUD_DIV cycles.
  - Back-to-back frames have zero gap cycles.
- STATUS read is combinational. It shows state as of the last edge, so a write in the same cycle is not reflected until the next cycle.
- irq is deasserted at the edge that pushes into an empty idle block. It reasserts at the edge that enters IDLE with an empty FIFO.

## Test plan
- Reset: hold reset 3 cycles -> tx=1, irq=1, STATUS read = 0x0000_0002 (empty only).
- Single byte, BAUD_DIV=4: write 0xA5 to 0x0 at E0 -> tx low from E1 for 4 cycles. Then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles. irq rises at E41.
- Back-to-back: write 0x55 then 0x0F on consecutive cycles, BAUD_DIV=4 -> 80 cycles of continuous framing with no idle cycle between stop and start. Then IDLE and irq=1.
- Overflow, FIFO_DEPTH=4: six writes 0x01..0x06 on consecutive cycles -> 0x01 popped at E1, 0x02..0x05 queued (count=4, full). 0x06 dropped, STATUS = 0x4D (count 4, overflow, busy, full). Exactly five frames are transmitted.
- Overflow clear: write DataIn=1 to 0x4 -> overflow bit 0 next cycle. Write to 0x8 -> no state change, read 0x8 returns 0.
- Reset mid-frame: assert reset during DATA bit 3 with 2 bytes queued -> tx=1 after the edge, STATUS=0x02. No further frames are transmitted.
